// File: rtl/bram_fault_injector_if.sv
// Command, response and BRAM-port bundle for bram_fault_injector.
// slave  : the injector itself.
// master : the environment, which issues commands and models the BRAM.
interface bram_fault_injector_if;
    logic        Cmd_Valid;
    logic        Cmd_Ready;
    logic        Cmd_Op;
    logic [0:31] Cmd_Addr;
    logic [0:31] Cmd_Mask;

    logic        Rsp_Valid;
    logic        Rsp_Err;
    logic [0:31] Rsp_Old_Data;
    logic [0:31] Rsp_New_Data;

    logic        BRAM_EN;
    logic [0:3]  BRAM_WEN;
    logic [0:31] BRAM_Addr;
    logic [0:31] BRAM_Dout;
    logic [0:31] BRAM_Din;

    modport slave (
        input  Cmd_Valid, Cmd_Op, Cmd_Addr, Cmd_Mask, BRAM_Din,
        output Cmd_Ready, Rsp_Valid, Rsp_Err, Rsp_Old_Data, Rsp_New_Data,
        output BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );

    modport master (
        output Cmd_Valid, Cmd_Op, Cmd_Addr, Cmd_Mask, BRAM_Din,
        input  Cmd_Ready, Rsp_Valid, Rsp_Err, Rsp_Old_Data, Rsp_New_Data,
        input  BRAM_EN, BRAM_WEN, BRAM_Addr, BRAM_Dout
    );
endinterface

// File: rtl/bram_fault_injector.sv
// BRAM fault injector: drives one port of a dual-port BRAM and performs
// read-modify-write bit flips (new = old ^ mask) or plain readbacks.
// The other BRAM port is not arbitrated; a processor write to the same word
// between the read and the write of a flip is overwritten.
// Optional build macro FI_WRITE_VERIFY_EN: after a flip the word is read back
// and Rsp_Err is raised if it differs from the value written.
module bram_fault_injector #(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter int unsigned C_MEMSIZE     = 32'h0000_8000,
    parameter int unsigned C_PORT_DWIDTH = 32,
    parameter int unsigned C_CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    bram_fault_injector_if.slave   bus,
    output logic [C_CNT_WIDTH-1:0] Inject_Count,
    output logic                   BRAM_Rst,
    output logic                   BRAM_Clk
);

    localparam int unsigned DW       = C_PORT_DWIDTH;
    localparam int unsigned BE_W     = DW / 8;
    localparam logic [32:0] RANGE_LO = 33'(C_BASEADDR);

`ifdef FI_WRITE_VERIFY_EN
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, VRD, VCAP, RSP} state_e;
`else
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RSP} state_e;
`endif

    state_e                 state_q;
    logic                   ready_q;
    logic                   op_q;
    logic                   en_q;
    logic [0:BE_W-1]        wen_q;
    logic [0:31]            addr_q;
    logic [0:DW-1]          mask_q;
    logic [0:DW-1]          dout_q;
    logic [0:DW-1]          old_q;
    logic [0:DW-1]          new_q;
    logic                   err_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [0:DW-1]          rsp_old_q;
    logic [0:DW-1]          rsp_new_q;
    logic [C_CNT_WIDTH-1:0] cnt_q;

    logic [0:31]            addr_c;
    logic [32:0]            offset_c;
    logic                   in_range_c;

    // Word-align the command address and range-check it as an offset from
    // the base: a borrow means below base, otherwise compare against size.
    always_comb begin
        addr_c     = bus.Cmd_Addr & 32'hFFFF_FFFC;
        offset_c   = 33'(addr_c) - RANGE_LO;
        in_range_c = !offset_c[32] && (offset_c[31:0] < 32'(C_MEMSIZE));
    end

    // Command FSM with all BRAM and response outputs registered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            op_q        <= 1'b0;
            en_q        <= 1'b0;
            wen_q       <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            dout_q      <= '0;
            old_q       <= '0;
            new_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_old_q   <= '0;
            rsp_new_q   <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Cmd_Valid) begin
                        ready_q <= 1'b0;
                        op_q    <= bus.Cmd_Op;
                        mask_q  <= bus.Cmd_Mask;
                        err_q   <= !in_range_c;
                        if (in_range_c) begin
                            state_q <= RD;
                            en_q    <= 1'b1;
                            addr_q  <= addr_c;
                        end else begin
                            state_q <= RSP;
                            old_q   <= '0;
                            new_q   <= '0;
                        end
                    end
                end
                RD: begin
                    en_q    <= 1'b0;
                    state_q <= CAP;
                end
                CAP: begin
                    old_q <= bus.BRAM_Din;
                    if (!op_q && (mask_q != '0)) begin
                        new_q   <= bus.BRAM_Din ^ mask_q;
                        dout_q  <= bus.BRAM_Din ^ mask_q;
                        en_q    <= 1'b1;
                        wen_q   <= '1;
                        state_q <= WR;
                    end else begin
                        new_q   <= bus.BRAM_Din;
                        state_q <= RSP;
                    end
                end
                WR: begin
                    wen_q <= '0;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + C_CNT_WIDTH'(1);
                    end
`ifdef FI_WRITE_VERIFY_EN
                    state_q <= VRD;
`else
                    en_q    <= 1'b0;
                    state_q <= RSP;
`endif
                end
`ifdef FI_WRITE_VERIFY_EN
                VRD: begin
                    en_q    <= 1'b0;
                    state_q <= VCAP;
                end
                VCAP: begin
                    err_q   <= (bus.BRAM_Din != new_q);
                    state_q <= RSP;
                end
`endif
                RSP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_old_q   <= old_q;
                    rsp_new_q   <= new_q;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    en_q    <= 1'b0;
                    wen_q   <= '0;
                end
            endcase
        end
    end

    // Output mapping; the BRAM port shares the system clock and never resets.
    assign bus.Cmd_Ready    = ready_q;
    assign bus.Rsp_Valid    = rsp_valid_q;
    assign bus.Rsp_Err      = rsp_err_q;
    assign bus.Rsp_Old_Data = rsp_old_q;
    assign bus.Rsp_New_Data = rsp_new_q;
    assign bus.BRAM_EN      = en_q;
    assign bus.BRAM_WEN     = wen_q;
    assign bus.BRAM_Addr    = addr_q;
    assign bus.BRAM_Dout    = dout_q;
    assign Inject_Count     = cnt_q;
    assign BRAM_Rst         = 1'b0;
    assign BRAM_Clk         = Clk;

endmodule

// File: tb/tb_bram_fault_injector.sv
// Testbench for bram_fault_injector: BRAM behavioural model on the port,
// word-level reference memory, expected responses queued at issue time and
// compared by an independent response monitor.
module tb_bram_fault_injector;

    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int unsigned MEMSIZE = 32'h0000_8000;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORDS   = MEMSIZE / 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef FI_WRITE_VERIFY_EN
    localparam int          FLIP_LAT = 6;
`else
    localparam int          FLIP_LAT = 4;
`endif

    logic             Clk = 1'b0;
    logic             Rst_n;
    logic [CNT_W-1:0] inject_count;
    logic             bram_rst;
    logic             bram_clk;

    bram_fault_injector_if bus();

    bram_fault_injector #(
        .C_BASEADDR   (BASE),
        .C_MEMSIZE    (MEMSIZE),
        .C_PORT_DWIDTH(32),
        .C_CNT_WIDTH  (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .bus         (bus),
        .Inject_Count(inject_count),
        .BRAM_Rst    (bram_rst),
        .BRAM_Clk    (bram_clk)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          err;
        logic [31:0] old_d;
        logic [31:0] new_d;
        int          cnt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] bram_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];
    int          ref_cnt = 0;
    int          en_cycles = 0;
    int          wr_cycles = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    bit          corrupt_vrd = 1'b0;
    bit          prev_wr = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // BRAM port model: synchronous read with one cycle latency, byte-lane writes.
    always @(posedge bram_clk) begin : bram_model
        int          idx;
        logic [31:0] w;
        logic [31:0] d;
        if (bus.BRAM_EN) begin
            idx       = int'((32'(bus.BRAM_Addr) >> 2) % WORDS);
            en_cycles <= en_cycles + 1;
            if (bus.BRAM_WEN != 4'h0) begin
                w = bram_mem[idx];
                d = bus.BRAM_Dout;
                for (int b = 0; b < 4; b++) begin
                    if (bus.BRAM_WEN[b]) w[31-8*b -: 8] = d[31-8*b -: 8];
                end
                bram_mem[idx] = w;
                wr_cycles    <= wr_cycles + 1;
                last_wr_addr <= bus.BRAM_Addr;
                last_wr_data <= bus.BRAM_Dout;
                prev_wr      <= 1'b1;
            end else begin
                bus.BRAM_Din <= (corrupt_vrd && prev_wr) ? (bram_mem[idx] ^ 32'h1) : bram_mem[idx];
                last_rd_addr <= bus.BRAM_Addr;
                prev_wr      <= 1'b0;
            end
        end else begin
            prev_wr <= 1'b0;
        end
    end

    // Response monitor and BRAM address legality.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Rst_n && bus.BRAM_EN) begin
            check("bram_addr_legal",
                  64'((bus.BRAM_Addr[30:31] == 2'b00) && (32'(bus.BRAM_Addr) < MEMSIZE)), 64'd1);
        end
        if (bus.Rsp_Valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got Rsp_Valid with no command pending (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check("rsp_err",      64'(bus.Rsp_Err),      64'(e.err));
                check("rsp_old",      64'(bus.Rsp_Old_Data), 64'(e.old_d));
                check("rsp_new",      64'(bus.Rsp_New_Data), 64'(e.new_d));
                check("inject_count", 64'(inject_count),     64'(e.cnt));
                check("rsp_latency",  64'(cyc - e.acc),      64'(e.lat));
            end
        end
    end

    // Issue one command from a negedge; returns at the negedge where Cmd_Ready is back.
    task automatic send(input bit op, input logic [31:0] addr, input logic [31:0] mask,
                        input bit keep, input bit verr);
        exp_t            e;
        int              n;
        int              idx;
        logic [31:0]     al;
        longint unsigned a;
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = op;
        bus.Cmd_Addr  = addr;
        bus.Cmd_Mask  = mask;
        n = 0;
        while (bus.Cmd_Ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: Cmd_Ready stuck at %b, required 1", bus.Cmd_Ready);
            bus.Cmd_Valid = 1'b0;
            return;
        end
        al = addr & 32'hFFFF_FFFC;
        a  = longint'(al);
        if (a < longint'(BASE) || a >= longint'(BASE) + longint'(MEMSIZE)) begin
            e.err = 1'b1; e.old_d = '0; e.new_d = '0; e.lat = 1;
        end else begin
            idx     = int'((al - BASE) >> 2);
            e.old_d = ref_mem[idx];
            if (!op && mask != 32'h0) begin
                e.new_d      = e.old_d ^ mask;
                ref_mem[idx] = e.new_d;
                if (ref_cnt < CNT_MAX) ref_cnt++;
                e.lat = FLIP_LAT;
                e.err = verr;
            end else begin
                e.new_d = e.old_d;
                e.lat   = 3;
                e.err   = 1'b0;
            end
        end
        e.cnt = ref_cnt;
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
        if (!keep) bus.Cmd_Valid = 1'b0;
        n = 0;
        while (bus.Cmd_Ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge Clk);
        end
        check("ready_low_cycles", 64'(n), 64'(e.lat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          w0;
        int          e0;
        int          mism;
        bit          keep;
        bit          prev_keep;
        bit          op;
        int          r;
        logic [31:0] addr;
        logic [31:0] mask;

        Rst_n         = 1'b0;
        bus.Cmd_Valid = 1'b0;
        bus.Cmd_Op    = 1'b0;
        bus.Cmd_Addr  = '0;
        bus.Cmd_Mask  = '0;
        bus.BRAM_Din  = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            bram_mem[i] = $urandom;
            ref_mem[i]  = bram_mem[i];
        end

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_cmd_ready", 64'(bus.Cmd_Ready),    64'd1);
        check("rst_bram_en",   64'(bus.BRAM_EN),      64'd0);
        check("rst_bram_wen",  64'(bus.BRAM_WEN),     64'd0);
        check("rst_bram_addr", 64'(bus.BRAM_Addr),    64'd0);
        check("rst_bram_dout", 64'(bus.BRAM_Dout),    64'd0);
        check("rst_rsp_valid", 64'(bus.Rsp_Valid),    64'd0);
        check("rst_rsp_err",   64'(bus.Rsp_Err),      64'd0);
        check("rst_rsp_old",   64'(bus.Rsp_Old_Data), 64'd0);
        check("rst_rsp_new",   64'(bus.Rsp_New_Data), 64'd0);
        check("rst_count",     64'(inject_count),     64'd0);
        check("bram_rst_tied", 64'(bram_rst),         64'd0);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        check("idle_no_bram_activity", 64'(en_cycles), 64'd0);

        // Directed flip
        bram_mem[4] = 32'hA5A5_A5A5;
        ref_mem[4]  = 32'hA5A5_A5A5;
        send(1'b0, 32'h10, 32'h8000_0001, 1'b0, 1'b0);
        check("flip_rd_addr", 64'(last_rd_addr), 64'h10);
        check("flip_wr_addr", 64'(last_wr_addr), 64'h10);
        check("flip_wr_data", 64'(last_wr_data), 64'h25A5_A5A4);

        // Readback of unaligned address, then zero mask: no writes
        w0 = wr_cycles;
        send(1'b1, 32'h13, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("readback_rd_addr",  64'(last_rd_addr), 64'h10);
        check("readback_no_write", 64'(wr_cycles),    64'(w0));
        send(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        check("mask0_no_write",    64'(wr_cycles),    64'(w0));

        // Range boundaries
        e0 = en_cycles;
        send(1'b0, MEMSIZE, 32'hF, 1'b0, 1'b0);
        send(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        check("range_err_no_bram", 64'(en_cycles), 64'(e0));
        send(1'b0, MEMSIZE - 4, 32'h1, 1'b0, 1'b0);
        check("last_word_wr_addr", 64'(last_wr_addr), 64'(MEMSIZE - 4));

        // Back-to-back with Cmd_Valid held high
        send(1'b0, 32'h40, 32'h0000_FF00, 1'b1, 1'b0);
        send(1'b1, 32'h44, 32'h0,         1'b1, 1'b0);
        send(1'b0, 32'h0001_0000, 32'h1,  1'b1, 1'b0);
        send(1'b0, 32'h40, 32'h1234_5678, 1'b0, 1'b0);

        // Reset in the first half of the write cycle
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = 1'b0;
        bus.Cmd_Addr  = 32'h20;
        bus.Cmd_Mask  = 32'hFFFF_FFFF;
        @(posedge Clk);
        #1 bus.Cmd_Valid = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("midrst_wr_en",  64'(bus.BRAM_EN),  64'd1);
        check("midrst_wr_wen", 64'(bus.BRAM_WEN), 64'hF);
        Rst_n = 1'b0;
        #1;
        check("midrst_async_en",  64'(bus.BRAM_EN),   64'd0);
        check("midrst_async_wen", 64'(bus.BRAM_WEN),  64'd0);
        check("midrst_ready",     64'(bus.Cmd_Ready), 64'd1);
        repeat (3) @(negedge Clk);
        Rst_n   = 1'b1;
        ref_cnt = 0;
        @(negedge Clk);
        check("midrst_no_write", 64'(bram_mem[8]),  64'(ref_mem[8]));
        check("midrst_count",    64'(inject_count), 64'd0);
        send(1'b0, 32'h20, 32'hFFFF_FFFF, 1'b0, 1'b0);

`ifdef FI_WRITE_VERIFY_EN
        // Corrupted verify readback must raise Rsp_Err
        corrupt_vrd = 1'b1;
        send(1'b0, 32'h30, 32'h0F0F_0F0F, 1'b0, 1'b1);
        corrupt_vrd = 1'b0;
        bram_mem[12] = ref_mem[12];
`endif

        // Randomized traffic with occasional processor-side writes
        prev_keep = 1'b0;
        for (int k = 0; k < 150; k++) begin
            if (!prev_keep) begin
                repeat ($urandom_range(0, 2)) @(negedge Clk);
                if ($urandom_range(0, 7) == 0) begin
                    r = int'($urandom_range(0, WORDS - 1));
                    bram_mem[r] = $urandom;
                    ref_mem[r]  = bram_mem[r];
                end
            end
            op = ($urandom_range(0, 3) == 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0)      addr = MEMSIZE + 4 * $urandom_range(0, 1000);
            else if (r == 1) addr = $urandom;
            else             addr = $urandom_range(0, MEMSIZE - 1);
            mask = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            keep = (k != 149) && ($urandom_range(0, 2) == 0);
            send(op, addr, mask, keep, 1'b0);
            prev_keep = keep;
        end

        repeat (10) @(negedge Clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        check("final_count",        64'(inject_count), 64'(ref_cnt));
        mism = 0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (bram_mem[i] !== ref_mem[i]) mism++;
        end
        check("memory_image", 64'(mism), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
